// File: rtl/alu_result_drain.sv
// rtl/alu_result_drain.sv - first-word-fall-through buffer draining ALU results to a consumer
//
// Purpose: buffers 32-bit ALU result words between the ALU result path
// (producer) and writeback or a debug port (consumer), so that ALU completion
// timing is decoupled from consumer stalls.
//
// Optional feature macro: RESULT_DRAIN_OVF_EN adds the sticky ovf output.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   flush     synchronous clear of all entries (and ovf)
//   wr_valid  producer offers wr_data
//   wr_data   ALU result word
//   wr_ready  buffer can accept (not full)
//   rd_valid  rd_data holds the oldest word (not empty)
//   rd_ready  consumer takes rd_data
//   rd_data   oldest stored word, zero when empty
//   level     number of stored words, 0..DEPTH
//   ovf       sticky "write offered while full" flag (RESULT_DRAIN_OVF_EN only)

module alu_result_drain #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_valid,
  input  logic [31:0]   wr_data,
  output logic          wr_ready,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [31:0]   rd_data,
`ifdef RESULT_DRAIN_OVF_EN
  output logic          ovf,
`endif
  output logic [AW:0]   level
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_wr, do_rd, mem_we;

  // Full/empty come from the registered level only, so wr_ready never looks
  // ahead to a same-cycle read and there is no wr_valid->rd_valid or
  // rd_ready->wr_ready combinational path.
  always_comb begin
    wr_ready = (level_q != (AW+1)'(DEPTH));
    rd_valid = (level_q != '0);
    do_wr    = wr_valid && wr_ready;
    do_rd    = rd_valid && rd_ready;
    mem_we   = do_wr && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_wr && !do_rd) level_d = level_q + (AW+1)'(1);
      else if (do_rd && !do_wr) level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately not reset; stale contents are masked by rd_valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = rd_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign level   = level_q;

`ifdef RESULT_DRAIN_OVF_EN
  logic ovf_q, ovf_d;

  // Flush beats a same-edge overflow event.
  always_comb begin
    ovf_d = ovf_q;
    if (flush) ovf_d = 1'b0;
    else if (wr_valid && !wr_ready) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_result_drain.sv
// tb/tb_alu_result_drain.sv - scoreboard bench for alu_result_drain (DEPTH=4)

module tb_alu_result_drain;

  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_valid;
  logic [31:0]   wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic          rd_ready;
  logic [31:0]   rd_data;
  logic [AW:0]   level;
`ifdef RESULT_DRAIN_OVF_EN
  logic          ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  alu_result_drain #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
`ifdef RESULT_DRAIN_OVF_EN
    .ovf      (ovf),
`endif
    .level    (level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [31:0] d, input bit accept);
    wr_valid = 1'b1;
    wr_data  = d;
    if (accept) exp_q.push_back(d);
    tick();
    wr_valid = 1'b0;
  endtask

  // Monitor: a read happens on the next edge whenever valid && ready.
  always @(negedge clk) begin
    if (rst_n && !flush && rd_valid && rd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor_unexpected: got %h expected no word", rd_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL monitor_data: got %h expected %h", rd_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b1; wr_data = 32'hAAAA_5555; rd_ready = 1'b0;
    repeat (3) tick();
    check("rst_level", 32'(level), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_rd_data", rd_data, 0);
`ifdef RESULT_DRAIN_OVF_EN
    check("rst_ovf", 32'(ovf), 0);
`endif
    rst_n = 1'b1;
    #1;
    check("release_level", 32'(level), 0);
    wr_valid = 1'b0;
    tick();
    check("release_no_write", 32'(rd_valid), 0);

    // Single word
    write(32'hDEADBEEF, 1'b1);
    check("single_rd_valid", 32'(rd_valid), 1);
    check("single_rd_data", rd_data, 32'hDEADBEEF);
    check("single_level", 32'(level), 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("single_drained_valid", 32'(rd_valid), 0);
    check("single_drained_level", 32'(level), 0);

    // Fill, overflow, drain
    for (int i = 1; i <= 4; i++) write(32'(i), 1'b1);
    check("full_wr_ready", 32'(wr_ready), 0);
    check("full_level", 32'(level), 4);
    rd_ready = 1'b1;
    wr_valid = 1'b1; wr_data = 32'd5;
    tick();
    // Full cycle: read completes but the write is refused even with rd_ready=1.
    wr_valid = 1'b0; rd_ready = 1'b0;
    check("full_no_lookahead_level", 32'(level), 3);
`ifdef RESULT_DRAIN_OVF_EN
    check("ovf_set", 32'(ovf), 1);
`endif
    rd_ready = 1'b1;
    repeat (3) tick();
    rd_ready = 1'b0;
    check("drain_level", 32'(level), 0);
    check("drain_rd_data_zero", rd_data, 0);
`ifdef RESULT_DRAIN_OVF_EN
    check("ovf_sticky", 32'(ovf), 1);
`endif

    // Simultaneous write and read at level 2
    write(32'd10, 1'b1);
    write(32'd11, 1'b1);
    wr_valid = 1'b1; wr_data = 32'd12; exp_q.push_back(32'd12);
    rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0; rd_ready = 1'b0;
    check("simul_level", 32'(level), 2);
    check("simul_rd_data", rd_data, 32'd11);
    rd_ready = 1'b1;
    repeat (2) tick();
    rd_ready = 1'b0;
    check("simul_drain_level", 32'(level), 0);

    // Streaming with wrap-around
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1; wr_data = 32'h100 + 32'(i);
      exp_q.push_back(32'h100 + 32'(i));
      tick();
      check("stream_level", 32'(level), 1);
    end
    wr_valid = 1'b0;
    tick();
    rd_ready = 1'b0;
    check("stream_end_level", 32'(level), 0);
    check("stream_all_read", 32'(exp_q.size()), 0);

    // Flush at level 3 with a same-cycle write
    write(32'd20, 1'b1);
    write(32'd21, 1'b1);
    write(32'd22, 1'b1);
    check("preflush_level", 32'(level), 3);
    flush = 1'b1; wr_valid = 1'b1; wr_data = 32'd99;
    tick();
    flush = 1'b0; wr_valid = 1'b0;
    exp_q.delete();
    check("flush_level", 32'(level), 0);
    check("flush_rd_valid", 32'(rd_valid), 0);
    check("flush_wr_ready", 32'(wr_ready), 1);
    check("flush_rd_data", rd_data, 0);
`ifdef RESULT_DRAIN_OVF_EN
    check("flush_ovf", 32'(ovf), 0);
`endif
    write(32'd30, 1'b1);
    check("postflush_rd_data", rd_data, 32'd30);
    check("postflush_level", 32'(level), 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;

    // Asynchronous reset between edges
    write(32'd40, 1'b1);
    write(32'd41, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst_level", 32'(level), 0);
    check("async_rst_rd_valid", 32'(rd_valid), 0);
    check("async_rst_rd_data", rd_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("after_rst_level", 32'(level), 0);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
